// File: rtl/dilate_3x3_pkg.sv
// dilate_3x3_pkg: shared raster defaults, window/edge types and the border-masking helper
// used by the 3x3 binary dilation stage.
package dilate_3x3_pkg;

    localparam int DEF_COL = 1280;
    localparam int DEF_ROW = 720;

    // Flags captured with each window: which taps fall outside the frame.
    typedef struct packed {
        logic row1;
        logic row2;
        logic col1;
        logic col2;
    } edge_t;

    // taps[0] = column c, taps[1] = c-1, taps[2] = c-2
    function automatic logic [2:0] mask_taps(input logic [2:0] taps, input logic row_off, input edge_t e);
        return row_off ? 3'b000 : {taps[2] & ~e.col2, taps[1] & ~e.col1, taps[0]};
    endfunction

endpackage

// File: rtl/line_buf_1b.sv
// line_buf_1b: synchronous 1-bit RAM with registered read; a read and a write on the
// same address in the same cycle returns the old contents.
module line_buf_1b #(
    parameter int DEPTH = 1280,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic          i_wd,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic          o_q
);

    logic r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       o_q <= 1'b0;
        else if (i_re) o_q <= r_mem[i_raddr];
    end

endmodule

// File: rtl/dilate_3x3.sv
// dilate_3x3: binary 3x3 dilation of a 1-bit mask stream, window ending at the current
// pixel, frame borders masked, fixed 3-clock latency with optional bypass.
module dilate_3x3
    import dilate_3x3_pkg::*;
#(
    parameter int U_COL = DEF_COL,
    parameter int U_ROW = DEF_ROW
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in_de,
    input  logic in_data,
    output logic out_de,
    output logic out_data,
    output logic frame_done
);

    localparam int CNT_W = $clog2(U_COL);
    localparam int ROW_W = $clog2(U_ROW);

    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_col_d;
    logic [ROW_W-1:0] r_row;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_lb1_q;
    logic             w_lb2_q;
    logic [2:0]       r_bot;
    logic [1:0]       r_mid_sh;
    logic [1:0]       r_top_sh;
    logic [2:0]       w_mid;
    logic [2:0]       w_top;
    edge_t            r_edge;
    logic [2:0]       r_or;
    logic             r_ctr;
    logic [2:0]       r_de;
    logic [2:0]       r_tag;

    assign w_col_last = r_col == CNT_W'(U_COL - 1);
    assign w_row_last = r_row == ROW_W'(U_ROW - 1);
    assign w_mid      = {r_mid_sh, w_lb1_q};
    assign w_top      = {r_top_sh, w_lb2_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col   <= '0;
            r_col_d <= '0;
            r_row   <= '0;
        end else if (in_de) begin
            r_col   <= w_col_last ? '0 : r_col + 1'b1;
            r_col_d <= r_col;
            r_row   <= w_col_last ? (w_row_last ? '0 : r_row + 1'b1) : r_row;
        end
    end

    // lb1 holds the previous line; its read port doubles as the (r-1, c) tap.
    line_buf_1b #(.DEPTH(U_COL), .AW(CNT_W)) u_lb1 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (in_de),
        .i_waddr (r_col),
        .i_wd    (in_data),
        .i_re    (in_de),
        .i_raddr (r_col),
        .o_q     (w_lb1_q)
    );

    // lb2 receives lb1's old contents one valid pixel later, at the column just read.
    line_buf_1b #(.DEPTH(U_COL), .AW(CNT_W)) u_lb2 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (in_de),
        .i_waddr (r_col_d),
        .i_wd    (w_lb1_q),
        .i_re    (in_de),
        .i_raddr (r_col),
        .o_q     (w_lb2_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bot    <= '0;
            r_mid_sh <= '0;
            r_top_sh <= '0;
            r_edge   <= '0;
        end else if (in_de) begin
            r_bot    <= {r_bot[1:0], in_data};
            r_mid_sh <= {r_mid_sh[0], w_lb1_q};
            r_top_sh <= {r_top_sh[0], w_lb2_q};
            r_edge   <= '{row1: r_row == '0, row2: r_row < ROW_W'(2),
                          col1: r_col == '0, col2: r_col < CNT_W'(2)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_or     <= '0;
            r_ctr    <= 1'b0;
            out_data <= 1'b0;
            r_de     <= '0;
            r_tag    <= '0;
        end else begin
            r_or     <= {|mask_taps(w_top, r_edge.row2, r_edge),
                         |mask_taps(w_mid, r_edge.row1, r_edge),
                         |mask_taps(r_bot, 1'b0, r_edge)};
            r_ctr    <= r_bot[0];
            out_data <= en ? |r_or : r_ctr;
            r_de     <= {r_de[1:0], in_de};
            r_tag    <= {r_tag[1:0], in_de & w_col_last & w_row_last};
        end
    end

    assign out_de     = r_de[2];
    assign frame_done = r_tag[2];

endmodule

// File: tb/tb_dilate_3x3.sv
// tb_dilate_3x3: directed frames on an 8x6 raster; every output pixel is compared against
// a direct window-OR reference of the driven image.
module tb_dilate_3x3;

    localparam int NC = 8;
    localparam int NR = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic in_de = 1'b0;
    logic in_data = 1'b0;
    logic out_de;
    logic out_data;
    logic frame_done;

    dilate_3x3 #(.U_COL(NC), .U_ROW(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_de      (in_de),
        .in_data    (in_data),
        .out_de     (out_de),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit d;
        bit last;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   img [NR][NC];
    exp_t exq [$];
    int   ones = 0;
    int   fd_cnt = 0;
    int   out_idx = 0;
    int   fd_prev = -1;
    bit [2:0] de_hist = '0;

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic bit model(input int r, input int c, input bit e);
        bit v = 1'b0;
        if (!e) return img[r][c];
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                if (r - dr >= 0 && c - dc >= 0) v |= img[r-dr][c-dc];
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_out_de", out_de, 1'b0);
            chk("rst_out_data", out_data, 1'b0);
            chk("rst_frame_done", frame_done, 1'b0);
            exq.delete();
            de_hist = '0;
            fd_prev = -1;
        end else begin
            chk("de_delay", out_de, de_hist[2]);
            if (out_de) begin
                chk_int("pixel_expected", int'(exq.size() > 0), 1);
                if (exq.size() > 0) begin
                    e = exq.pop_front();
                    chk("pix", out_data, e.d);
                    chk("frame_done", frame_done, e.last);
                    ones += int'(out_data);
                    out_idx++;
                    if (frame_done) begin
                        fd_cnt++;
                        if (fd_prev >= 0) chk_int("fd_spacing", out_idx - fd_prev, NC * NR);
                        fd_prev = out_idx;
                    end
                end
            end else begin
                chk("fd_idle", frame_done, 1'b0);
            end
            de_hist = {de_hist[1:0], in_de};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            in_de = 1'b0;
            in_data = 1'($urandom);
        end
    endtask

    task automatic send_frame(input bit gap, input int npix);
        for (int i = 0; i < npix; i++) begin
            int r = i / NC;
            int c = i % NC;
            if (gap) idle(1);
            tick();
            in_de = 1'b1;
            in_data = img[r][c];
            exq.push_back('{d: model(r, c, en), last: (r == NR - 1 && c == NC - 1)});
        end
    endtask

    task automatic set_img(input int kind);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                img[r][c] = (kind == 1) ? 1'((r + c) & 1) : 1'b0;
    endtask

    task automatic run_frame(input bit gap, input int ones_exp, input string tag);
        ones = 0;
        send_frame(gap, NR * NC);
        idle(6);
        chk_int(tag, ones, ones_exp);
    endtask

    initial begin
        int fd_snap;
        // Reset held with in_de toggling: monitor checks all outputs stay low.
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            in_de = 1'(i & 1);
            in_data = 1'b1;
        end
        tick();
        rst = 1'b0;
        in_de = 1'b0;
        idle(3);

        set_img(0);
        img[2][3] = 1'b1;
        run_frame(0, 9, "dot_ones");

        set_img(0);
        img[0][0] = 1'b1;
        run_frame(0, 9, "corner_ones");

        set_img(0);
        img[2][7] = 1'b1;
        img[5][7] = 1'b1;
        run_frame(0, 4, "right_edge_ones");
        set_img(0);
        run_frame(0, 0, "no_leak_next_frame");

        set_img(0);
        img[2][3] = 1'b1;
        run_frame(1, 9, "gapped_dot_ones");

        en = 1'b0;
        set_img(1);
        run_frame(0, 24, "bypass_ones");
        en = 1'b1;
        run_frame(0, 47, "checker_dilate_ones");

        fd_snap = fd_cnt;
        set_img(0);
        img[2][3] = 1'b1;
        ones = 0;
        send_frame(0, NR * NC);
        send_frame(0, NR * NC);
        idle(6);
        chk_int("b2b_frame_done", fd_cnt - fd_snap, 2);
        chk_int("b2b_ones", ones, 18);

        set_img(1);
        send_frame(0, 20);
        tick();
        rst = 1'b1;
        in_de = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(2);
        fd_snap = fd_cnt;
        set_img(0);
        img[2][3] = 1'b1;
        run_frame(0, 9, "post_reset_dot_ones");
        chk_int("post_reset_frame_done", fd_cnt - fd_snap, 1);

        chk_int("queue_drained", exq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
